// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: ROM loader (port 0) and CPU (port 1) share one memory.
// Latency: combinational grant; read data returns two cycles after grant, writes complete in the grant cycle.
// Backpressure: a requester holds its request until gnt; hold masks the CPU; no grants while a read is in flight.
//
// Ports: fpga_clk / rst_in (async active-low); req/we/addr/wdata per requester; hold;
//        gnt0/1, rvalid0/1, rdata, busy; memory write port (mem_wr_*) and read port
//        (mem_rd_addr out, mem_rd_data in, one-cycle synchronous read latency).
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties);
//        left undefined, ties are resolved round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              fpga_clk,
    input  logic              rst_in,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              hold,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_wr_go,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t state;
    logic   rd_owner;     // which requester the in-flight read belongs to
    logic   arb_en;
    logic   elig0;
    logic   elig1;
    logic   pick0_tie;    // 1: requester 0 wins when both are eligible
    logic   win0;
    logic   win1;
    logic   sel_we;
    logic   [ADDR_W-1:0] sel_addr;
    logic   [DATA_W-1:0] sel_wdata;

`ifndef ARB_FIXED_PRIO_EN
    // Last requester granted; resets to 1 so requester 0 takes the first tie.
    logic last_gnt;
`endif

    always_comb begin
        // Grants are suppressed while reset is held so outputs are clean regardless of the clock.
        arb_en = rst_in && (state != RD_WAIT);
        elig0  = req0;
        elig1  = req1 && !hold;
`ifdef ARB_FIXED_PRIO_EN
        pick0_tie = 1'b1;
`else
        pick0_tie = last_gnt;
`endif
        win0 = arb_en && elig0 && (!elig1 || pick0_tie);
        win1 = arb_en && elig1 && !win0;

        // With no winner the mux falls through to requester 1's fields.
        sel_we    = win0 ? we0    : we1;
        sel_addr  = win0 ? addr0  : addr1;
        sel_wdata = win0 ? wdata0 : wdata1;

        gnt0        = win0;
        gnt1        = win1;
        mem_wr_go   = (win0 || win1) && sel_we;
        mem_wr_addr = sel_addr;
        mem_wr_data = sel_wdata;
        mem_rd_addr = sel_addr;
    end

    always_ff @(posedge fpga_clk or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            rd_owner <= 1'b0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if ((win0 || win1) && !sel_we) begin
                        state    <= RD_WAIT;
                        rd_owner <= win1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    rdata <= mem_rd_data;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_ff @(posedge fpga_clk or negedge rst_in) begin
        if (!rst_in) begin
            last_gnt <= 1'b1;
        end else if (win0 || win1) begin
            last_gnt <= win1;
        end
    end
`endif

    // Response strobes decode straight from state flops, so they are glitch-free and
    // drop immediately when reset pulls the state back to IDLE.
    assign rvalid0 = (state == RESP) && !rd_owner;
    assign rvalid1 = (state == RESP) &&  rd_owner;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              fpga_clk = 1'b0;
    logic              rst_in;
    logic              req0, req1, we0, we1, hold;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1, busy, mem_wr_go;
    logic [DATA_W-1:0] rdata, mem_wr_data, mem_rd_data;
    logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 fpga_clk = ~fpga_clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .fpga_clk    (fpga_clk),
        .rst_in      (rst_in),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .hold        (hold),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .rdata       (rdata),
        .busy        (busy),
        .mem_wr_go   (mem_wr_go),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
    );

    // Memory model: synchronous write, one-cycle synchronous read.
    always @(posedge fpga_clk) begin
        if (mem_wr_go) mem[mem_wr_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge fpga_clk);
        #1;
    endtask

    int prev_w;
    int exp_w;

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
        mem[12'h200] = 8'hA2;

        // Reset, with a request pending to show gnt is forced low.
        rst_in = 1'b0; hold = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h123; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 12'h000; wdata1 = 8'h00;
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_go", mem_wr_go, 0);
        tick; tick;
        rst_in = 1'b1; req0 = 1'b0;

        // CPU read of 0x200.
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h200;
        @(negedge fpga_clk);
        chk("rd_gnt1", gnt1, 1);
        chk("rd_gnt0", gnt0, 0);
        chk("rd_addr", mem_rd_addr, 12'h200);
        chk("rd_busy_n", busy, 0);
        chk("rd_wr_go", mem_wr_go, 0);
        tick; req1 = 1'b0;
        @(negedge fpga_clk);
        chk("rd_busy_n1", busy, 1);
        chk("rd_wait_gnt1", gnt1, 0);
        chk("rd_wait_rvalid1", rvalid1, 0);
        tick;
        @(negedge fpga_clk);
        chk("rd_rvalid1", rvalid1, 1);
        chk("rd_rvalid0", rvalid0, 0);
        chk("rd_rdata", rdata, 8'hA2);
        chk("rd_busy_n2", busy, 1);
        tick;
        @(negedge fpga_clk);
        chk("rd_done_rvalid1", rvalid1, 0);
        chk("rd_done_busy", busy, 0);

        // Loader write of 0xF0 to 0x050.
        tick;
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h050; wdata0 = 8'hF0;
        @(negedge fpga_clk);
        chk("wr_gnt0", gnt0, 1);
        chk("wr_go", mem_wr_go, 1);
        chk("wr_addr", mem_wr_addr, 12'h050);
        chk("wr_data", mem_wr_data, 8'hF0);
        tick; req0 = 1'b0; we0 = 1'b0;
        @(negedge fpga_clk);
        chk("wr_after_busy", busy, 0);
        chk("wr_after_rvalid0", rvalid0, 0);
        chk("wr_after_go", mem_wr_go, 0);

        // Read back 0x050 through port 0.
        tick;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h050;
        @(negedge fpga_clk);
        chk("rb_gnt0", gnt0, 1);
        tick; req0 = 1'b0;
        tick;
        @(negedge fpga_clk);
        chk("rb_rvalid0", rvalid0, 1);
        chk("rb_rdata", rdata, 8'hF0);
        tick;

        // Both requesters reading continuously. Last grant went to 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h050;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h200;
        prev_w = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge fpga_clk);
            if (i % 2 == 0) begin
`ifdef ARB_FIXED_PRIO_EN
                exp_w = 0;
`else
                exp_w = (i % 4 == 0) ? 1 : 0;
`endif
                chk("cont_gnt0", gnt0, (exp_w == 0) ? 1 : 0);
                chk("cont_gnt1", gnt1, (exp_w == 1) ? 1 : 0);
                if (i >= 2) begin
                    chk("cont_rvalid0", rvalid0, (prev_w == 0) ? 1 : 0);
                    chk("cont_rvalid1", rvalid1, (prev_w == 1) ? 1 : 0);
                    chk("cont_rdata", rdata, (prev_w == 1) ? 8'hA2 : 8'hF0);
                end
                prev_w = exp_w;
            end else begin
                chk("cont_wait_gnt0", gnt0, 0);
                chk("cont_wait_gnt1", gnt1, 0);
            end
            tick;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge fpga_clk);
        chk("cont_last_rvalid0", rvalid0, (prev_w == 0) ? 1 : 0);
        chk("cont_last_rvalid1", rvalid1, (prev_w == 1) ? 1 : 0);
        chk("cont_last_gnt0", gnt0, 0);
        tick;
        @(negedge fpga_clk);
        chk("cont_idle_busy", busy, 0);

        // CPU locked out by hold for 10 cycles.
        tick;
        hold = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 12'h200;
        for (int i = 0; i < 10; i++) begin
            @(negedge fpga_clk);
            chk("hold_gnt1", gnt1, 0);
            chk("hold_busy", busy, 0);
            tick;
        end
        hold = 1'b0;
        @(negedge fpga_clk);
        chk("unhold_gnt1", gnt1, 1);
        tick; req1 = 1'b0;

        // Now in RD_WAIT: reset pulse discards the read.
        rst_in = 1'b0;
        #2;
        chk("rstrd_busy", busy, 0);
        chk("rstrd_rdata", rdata, 0);
        chk("rstrd_rvalid1", rvalid1, 0);
        @(negedge fpga_clk);
        tick;
        rst_in = 1'b1;
        @(negedge fpga_clk);
        chk("post_rst_rvalid1", rvalid1, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rdata", rdata, 0);
        chk("post_rst_wr_go", mem_wr_go, 0);
        tick;
        @(negedge fpga_clk);
        chk("post_rst_rvalid1_b", rvalid1, 0);
        chk("post_rst_rvalid0_b", rvalid0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
